// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the multiplier/divider launch packet, unit status,
// and the dispatch slot contents.
package pipeline_pkg;
  localparam int XLEN_P       = 32;
  localparam int REG_ADDR_W_P = 5;

  typedef struct packed {
    logic                    valid;
    logic                    mul_start;
    logic                    div_start;
    logic [1:0]              mul_op;
    logic [1:0]              div_op;
    logic [XLEN_P-1:0]       a;
    logic [XLEN_P-1:0]       b;
    logic [REG_ADDR_W_P-1:0] rd;
    logic                    wren;
  } mul_t;

  typedef struct packed {
    logic                    busy;
    logic [REG_ADDR_W_P-1:0] rd;
  } mul_status_t;

  typedef struct packed {
    logic [1:0]              op;
    logic [XLEN_P-1:0]       a;
    logic [XLEN_P-1:0]       b;
    logic [REG_ADDR_W_P-1:0] rd;
    logic                    wren;
  } md_slot_t;

  typedef enum logic {MUL_U = 1'b0, DIV_U = 1'b1} md_unit_e;
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} md_state_e;

  // x0 is hardwired to zero and never creates a dependency.
  function automatic logic rd_hit(logic [REG_ADDR_W_P-1:0] chk,
                                  logic [REG_ADDR_W_P-1:0] rd);
    return (chk != '0) && (chk == rd);
  endfunction
endpackage

// File: rtl/md_issue_slot.sv
// One holding slot for a MUL or DIV unit: EMPTY/FULL FSM, post-launch guard
// and the pending-rd match used by the hazard stall.
module md_issue_slot
  import pipeline_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_accept,
  input  logic                    i_launch,
  input  md_slot_t                i_slot,
  input  mul_status_t             i_fb,
  input  logic                    i_chk_valid,
  input  logic [REG_ADDR_W_P-1:0] i_chk_rs1,
  input  logic [REG_ADDR_W_P-1:0] i_chk_rs2,
  input  logic [REG_ADDR_W_P-1:0] i_chk_rd,
  output logic                    o_full,
  output logic                    o_eligible,
  output logic                    o_match,
  output md_slot_t                o_slot
);
  md_state_e                 state_q, state_d;
  md_slot_t                  slot_q;
  logic                      guard_q;
  logic [REG_ADDR_W_P-1:0]   grd_q;
  logic [2:0][REG_ADDR_W_P-1:0] chk;

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state_q <= S_EMPTY;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (i_accept && !i_flush)  state_d = S_FULL;
      S_FULL:  if (i_flush || i_launch)   state_d = S_EMPTY;
      default:                            state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    o_full     = (state_q == S_FULL);
    o_eligible = o_full && !i_fb.busy && !guard_q;
    o_slot     = slot_q;
  end

  // Guard covers the cycle before the unit's busy flag becomes visible.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      slot_q  <= '0;
      guard_q <= 1'b0;
      grd_q   <= '0;
    end else begin
      if (i_accept) slot_q <= i_slot;
      guard_q <= i_launch && !i_flush;
      if (i_launch) grd_q <= slot_q.rd;
    end

  assign chk = {i_chk_rd, i_chk_rs2, i_chk_rs1};

  always_comb begin
    o_match = 1'b0;
    for (int i = 0; i < 3; i++)
      o_match |= (o_full && slot_q.wren && rd_hit(chk[i], slot_q.rd)) ||
                 (i_fb.busy && rd_hit(chk[i], i_fb.rd)) ||
                 (guard_q && rd_hit(chk[i], grd_q));
    o_match &= i_chk_valid;
  end
endmodule

// File: rtl/mul_div_dispatch.sv
// MUL/DIV issue stage: one slot per unit, round-robin launch arbiter,
// single-cycle launch packet and RAW/WAW stall generation.
module mul_div_dispatch
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int XLEN       = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_is_mul,
  input  logic                  i_ex_is_div,
  input  logic [1:0]            i_ex_op,
  input  logic [XLEN-1:0]       i_ex_rs1_data,
  input  logic [XLEN-1:0]       i_ex_rs2_data,
  input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
  input  logic                  i_ex_wren,
  output logic                  o_ex_ready,
  input  logic                  i_chk_valid,
  input  logic [REG_ADDR_W-1:0] i_chk_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_chk_rs2_addr,
  input  logic [REG_ADDR_W-1:0] i_chk_rd_addr,
  output logic                  o_hazard_stall,
  input  mul_status_t           i_mul_fb_dat,
  input  mul_status_t           i_div_fb_dat,
  output mul_t                  o_abt_mul_dat
);
  logic [1:0]  full, elig, launch, accept, match;
  md_slot_t    slot_in;
  md_slot_t    slot_q [2];
  mul_status_t fb     [2];
  md_unit_e    rr_q;

  assign fb[0] = i_mul_fb_dat;
  assign fb[1] = i_div_fb_dat;

  always_comb begin
    slot_in      = '0;
    slot_in.op   = i_ex_op;
    slot_in.a    = i_ex_rs1_data;
    slot_in.b    = i_ex_rs2_data;
    slot_in.rd   = i_ex_rd_addr;
    slot_in.wren = i_ex_wren;
  end

  // Illegal both-targets encoding is rejected outright.
  assign o_ex_ready = !i_rst && i_ex_valid && !i_flush && (i_ex_is_mul ^ i_ex_is_div) &&
                      (i_ex_is_mul ? !full[0] : !full[1]);
  assign accept = {o_ex_ready && i_ex_is_div, o_ex_ready && i_ex_is_mul};

  for (genvar g = 0; g < 2; g++) begin : g_slot
    md_issue_slot u_slot (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_flush     (i_flush),
      .i_accept    (accept[g]),
      .i_launch    (launch[g]),
      .i_slot      (slot_in),
      .i_fb        (fb[g]),
      .i_chk_valid (i_chk_valid),
      .i_chk_rs1   (i_chk_rs1_addr),
      .i_chk_rs2   (i_chk_rs2_addr),
      .i_chk_rd    (i_chk_rd_addr),
      .o_full      (full[g]),
      .o_eligible  (elig[g]),
      .o_match     (match[g]),
      .o_slot      (slot_q[g])
    );
  end

  always_comb begin
    launch = 2'b00;
    if (!i_rst && !i_flush) begin
      if (elig == 2'b11) launch = (rr_q == MUL_U) ? 2'b01 : 2'b10;
      else               launch = elig;
    end
  end

  // Pointer only moves on a contended grant; flush leaves it alone.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)                            rr_q <= MUL_U;
    else if (!i_flush && elig == 2'b11)   rr_q <= (rr_q == MUL_U) ? DIV_U : MUL_U;

  always_comb begin
    o_abt_mul_dat = '0;
    if (launch[0]) begin
      o_abt_mul_dat.valid     = 1'b1;
      o_abt_mul_dat.mul_start = 1'b1;
      o_abt_mul_dat.mul_op    = slot_q[0].op;
      o_abt_mul_dat.a         = slot_q[0].a;
      o_abt_mul_dat.b         = slot_q[0].b;
      o_abt_mul_dat.rd        = slot_q[0].rd;
      o_abt_mul_dat.wren      = slot_q[0].wren;
    end else if (launch[1]) begin
      o_abt_mul_dat.valid     = 1'b1;
      o_abt_mul_dat.div_start = 1'b1;
      o_abt_mul_dat.div_op    = slot_q[1].op;
      o_abt_mul_dat.a         = slot_q[1].a;
      o_abt_mul_dat.b         = slot_q[1].b;
      o_abt_mul_dat.rd        = slot_q[1].rd;
      o_abt_mul_dat.wren      = slot_q[1].wren;
    end
  end

  assign o_hazard_stall = !i_rst && (|match);
endmodule

// File: tb/tb_mul_div_dispatch.sv
// Self-checking bench for mul_div_dispatch: directed scenarios plus random
// traffic compared against a slot/queue-level reference model.
module tb_mul_div_dispatch;
  import pipeline_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, ex_valid, is_mul, is_div, ex_wren, ready;
  logic [1:0]  ex_op;
  logic [31:0] rs1d, rs2d;
  logic [4:0]  ex_rd, c_rs1, c_rs2, c_rd;
  logic        chk_valid, stall;
  mul_status_t mfb, dfb;
  mul_t        pkt;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_dispatch #(.REG_ADDR_W(5), .XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_ex_valid(ex_valid), .i_ex_is_mul(is_mul), .i_ex_is_div(is_div),
    .i_ex_op(ex_op), .i_ex_rs1_data(rs1d), .i_ex_rs2_data(rs2d),
    .i_ex_rd_addr(ex_rd), .i_ex_wren(ex_wren), .o_ex_ready(ready),
    .i_chk_valid(chk_valid), .i_chk_rs1_addr(c_rs1), .i_chk_rs2_addr(c_rs2),
    .i_chk_rd_addr(c_rd), .o_hazard_stall(stall),
    .i_mul_fb_dat(mfb), .i_div_fb_dat(dfb), .o_abt_mul_dat(pkt)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: index 0 = MUL unit, 1 = DIV unit.
  bit          m_full [2];
  logic [1:0]  m_op   [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [4:0]  m_rd   [2];
  bit          m_wren [2];
  bit          m_grd_v[2];
  logic [4:0]  m_grd  [2];
  int          m_ptr;
  bit          e_ready, e_stall, e_contend;
  int          e_launch;
  mul_t        e_pkt;

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_full[u] = 0; m_grd_v[u] = 0; m_grd[u] = 0;
      m_op[u] = 0; m_a[u] = 0; m_b[u] = 0; m_rd[u] = 0; m_wren[u] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic model_comb();
    bit         busy[2], elig[2];
    logic [4:0] fbrd[2], ad[3];
    int         t;
    busy[0] = mfb.busy; busy[1] = dfb.busy;
    fbrd[0] = mfb.rd;   fbrd[1] = dfb.rd;
    t = is_mul ? 0 : 1;
    e_ready = !i_rst && ex_valid && (is_mul != is_div) && !m_full[t] && !i_flush;
    for (int u = 0; u < 2; u++) elig[u] = m_full[u] && !busy[u] && !m_grd_v[u];
    e_contend = elig[0] && elig[1];
    e_launch = -1;
    if (!i_rst && !i_flush) begin
      if (e_contend)    e_launch = m_ptr;
      else if (elig[0]) e_launch = 0;
      else if (elig[1]) e_launch = 1;
    end
    e_pkt = '0;
    if (e_launch >= 0) begin
      e_pkt.valid = 1'b1;
      if (e_launch == 0) begin e_pkt.mul_start = 1'b1; e_pkt.mul_op = m_op[0]; end
      else               begin e_pkt.div_start = 1'b1; e_pkt.div_op = m_op[1]; end
      e_pkt.a = m_a[e_launch]; e_pkt.b = m_b[e_launch];
      e_pkt.rd = m_rd[e_launch]; e_pkt.wren = m_wren[e_launch];
    end
    ad[0] = c_rs1; ad[1] = c_rs2; ad[2] = c_rd;
    e_stall = 0;
    if (!i_rst && chk_valid)
      for (int k = 0; k < 3; k++)
        if (ad[k] != 0)
          for (int u = 0; u < 2; u++)
            if ((m_full[u] && m_wren[u] && m_rd[u] == ad[k]) ||
                (busy[u] && fbrd[u] == ad[k]) ||
                (m_grd_v[u] && m_grd[u] == ad[k]))
              e_stall = 1;
  endtask

  task automatic model_clk();
    int t;
    if (i_rst) begin model_reset(); return; end
    if (i_flush) begin
      for (int u = 0; u < 2; u++) begin m_full[u] = 0; m_grd_v[u] = 0; end
      return;
    end
    for (int u = 0; u < 2; u++) m_grd_v[u] = (e_launch == u);
    if (e_launch >= 0) begin
      m_grd[e_launch] = m_rd[e_launch];
      m_full[e_launch] = 0;
    end
    if (e_ready) begin
      t = is_mul ? 0 : 1;
      m_full[t] = 1; m_op[t] = ex_op; m_a[t] = rs1d; m_b[t] = rs2d;
      m_rd[t] = ex_rd; m_wren[t] = ex_wren;
    end
    if (e_contend) m_ptr ^= 1;
  endtask

  task automatic tick();
    model_comb();
    @(posedge i_clk);
    model_clk();
    #1;
  endtask

  task automatic idle();
    i_flush = 0; ex_valid = 0; is_mul = 0; is_div = 0; ex_op = 0;
    rs1d = 0; rs2d = 0; ex_rd = 0; ex_wren = 0;
    chk_valid = 0; c_rs1 = 0; c_rs2 = 0; c_rd = 0;
  endtask

  task automatic present(input bit mul, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    ex_valid = 1; is_mul = mul; is_div = !mul; ex_op = op;
    rs1d = a; rs2d = b; ex_rd = rd; ex_wren = 1;
  endtask

  task automatic test_reset();
    i_rst = 1; idle(); mfb = '{busy: 1'b1, rd: 5'd3}; dfb = '0;
    present(1, 2'd1, 32'd1, 32'd2, 5'd3);
    chk_valid = 1; c_rs1 = 5'd3;
    @(posedge i_clk); #1;
    n_cmp++; if (pkt !== '0)  begin n_err++; $display("FAIL reset_pkt got %h want 0", pkt); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
    model_reset(); idle(); mfb = '0; i_rst = 0;
    tick();
  endtask

  task automatic test_single_mul();
    mul_t exp;
    present(1, 2'b00, 32'd7, 32'd6, 5'd5);
    #1; model_comb();
    n_cmp++; if (ready !== 1'b1 || ready !== e_ready) begin n_err++; $display("FAIL single_ready got %b want 1", ready); end
    tick(); idle(); #1;
    exp = '0; exp.valid = 1; exp.mul_start = 1; exp.a = 7; exp.b = 6; exp.rd = 5; exp.wren = 1;
    n_cmp++; if (pkt !== exp) begin n_err++; $display("FAIL single_pkt got %h want %h", pkt, exp); end
    tick(); #1;
    n_cmp++; if (pkt !== '0) begin n_err++; $display("FAIL single_after got %h want 0", pkt); end
    tick(); tick();
  endtask

  task automatic test_contention();
    for (int r = 0; r < 2; r++) begin
      mfb.busy = 1; dfb.busy = 1;
      present(1, 2'd1, $urandom, $urandom, 5'd1); tick();
      present(0, 2'd2, $urandom, $urandom, 5'd2); tick();
      idle(); mfb.busy = 0; dfb.busy = 0; #1; model_comb();
      n_cmp++;
      if (pkt !== e_pkt || pkt.mul_start !== (r == 0) || pkt.div_start !== (r == 1)) begin
        n_err++; $display("FAIL contend_first r=%0d got %h want %h", r, pkt, e_pkt);
      end
      tick(); #1; model_comb();
      n_cmp++;
      if (pkt !== e_pkt || pkt.mul_start !== (r == 1) || pkt.div_start !== (r == 0)) begin
        n_err++; $display("FAIL contend_second r=%0d got %h want %h", r, pkt, e_pkt);
      end
      tick(); tick();
    end
  endtask

  task automatic test_busy_block();
    dfb = '{busy: 1'b1, rd: 5'd0};
    present(0, 2'd3, 32'd100, 32'd7, 5'd3); tick();
    for (int c = 0; c < 30; c++) begin
      present(0, 2'd1, $urandom, $urandom, 5'd4); #1; model_comb();
      n_cmp++;
      if (ready !== 1'b0 || pkt.div_start !== 1'b0 || pkt !== e_pkt) begin
        n_err++; $display("FAIL busy_block c=%0d ready %b pkt %h want ready 0 pkt %h", c, ready, pkt, e_pkt);
      end
      tick();
    end
    idle(); dfb.busy = 0; #1; model_comb();
    n_cmp++;
    if (pkt.div_start !== 1'b1 || pkt.rd !== 5'd3 || pkt !== e_pkt) begin
      n_err++; $display("FAIL busy_release got %h want %h", pkt, e_pkt);
    end
    tick(); tick();
  endtask

  task automatic test_hazard();
    dfb = '{busy: 1'b1, rd: 5'd9};
    chk_valid = 1; c_rs2 = 5'd9; #1; model_comb();
    n_cmp++; if (stall !== 1'b1 || stall !== e_stall) begin n_err++; $display("FAIL hazard_rs2 got %b want 1", stall); end
    c_rs2 = 0; mfb = '{busy: 1'b1, rd: 5'd0};
    present(1, 2'd0, 32'd1, 32'd1, 5'd0); tick();
    idle(); chk_valid = 1; #1; model_comb();
    n_cmp++; if (stall !== 1'b0 || stall !== e_stall) begin n_err++; $display("FAIL hazard_x0 got %b want 0", stall); end
    idle(); mfb = '0; dfb = '0; tick(); tick(); tick();
  endtask

  task automatic test_guard();
    present(1, 2'd2, 32'd11, 32'd3, 5'd12); tick();
    present(1, 2'd1, 32'd5, 32'd5, 5'd13); #1; model_comb();
    n_cmp++;
    if (pkt.mul_start !== 1'b1 || ready !== 1'b0 || pkt !== e_pkt) begin
      n_err++; $display("FAIL guard_launch got %h ready %b want %h ready 0", pkt, ready, e_pkt);
    end
    tick();
    chk_valid = 1; c_rd = 5'd12; #1; model_comb();
    n_cmp++;
    if (pkt.valid !== 1'b0 || stall !== 1'b1 || stall !== e_stall) begin
      n_err++; $display("FAIL guard_hold pkt %h stall %b want pkt 0 stall 1", pkt, stall);
    end
    tick(); idle(); tick(); tick(); tick();
  endtask

  task automatic test_flush();
    mfb.busy = 1; dfb.busy = 1;
    present(1, 2'd1, 32'd9, 32'd9, 5'd6); tick();
    mfb.busy = 0; dfb.busy = 0;
    present(0, 2'd2, 32'd8, 32'd8, 5'd7); i_flush = 1; #1; model_comb();
    n_cmp++;
    if (pkt !== '0 || ready !== 1'b0 || ready !== e_ready) begin
      n_err++; $display("FAIL flush_cycle pkt %h ready %b want 0 0", pkt, ready);
    end
    tick(); idle(); #1; model_comb();
    n_cmp++; if (pkt !== '0 || pkt !== e_pkt) begin n_err++; $display("FAIL flush_after got %h want 0", pkt); end
    tick();
  endtask

  task automatic test_random();
    int sel;
    for (int c = 0; c < 400; c++) begin
      i_flush = ($urandom_range(0, 15) == 0);
      sel = $urandom_range(0, 3);
      ex_valid = ($urandom_range(0, 3) != 0);
      is_mul = (sel == 0 || sel == 2); is_div = (sel == 1 || sel == 2);
      ex_op = 2'($urandom); rs1d = $urandom; rs2d = $urandom;
      ex_rd = 5'($urandom_range(0, 7)); ex_wren = 1'($urandom);
      mfb = '{busy: ($urandom_range(0, 2) == 0), rd: 5'($urandom_range(0, 7))};
      dfb = '{busy: ($urandom_range(0, 2) == 0), rd: 5'($urandom_range(0, 7))};
      chk_valid = 1'($urandom);
      c_rs1 = 5'($urandom_range(0, 7)); c_rs2 = 5'($urandom_range(0, 7)); c_rd = 5'($urandom_range(0, 7));
      #1; model_comb();
      n_cmp++;
      if (pkt !== e_pkt || ready !== e_ready || stall !== e_stall) begin
        n_err++;
        $display("FAIL random c=%0d pkt %h ready %b stall %b want pkt %h ready %b stall %b",
                 c, pkt, ready, stall, e_pkt, e_ready, e_stall);
      end
      tick();
    end
    idle(); mfb = '0; dfb = '0; tick(); tick(); tick();
  endtask

  task automatic test_async_reset();
    mfb = '{busy: 1'b1, rd: 5'd4};
    present(1, 2'd3, 32'd21, 32'd2, 5'd4); tick();
    idle(); mfb = '0; #1;
    n_cmp++; if (pkt.valid !== 1'b1) begin n_err++; $display("FAIL areset_pre got %h want valid", pkt); end
    present(0, 2'd1, 32'd1, 32'd1, 5'd8);
    dfb = '{busy: 1'b1, rd: 5'd8}; chk_valid = 1; c_rs1 = 5'd8;
    i_rst = 1; #1;
    n_cmp++;
    if (pkt !== '0 || ready !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL areset_now pkt %h ready %b stall %b want 0 0 0", pkt, ready, stall);
    end
    model_reset(); tick(); idle(); dfb = '0; i_rst = 0; tick();
    present(1, 2'd0, 32'd2, 32'd3, 5'd1); #1; model_comb();
    n_cmp++; if (ready !== 1'b1 || ready !== e_ready) begin n_err++; $display("FAIL areset_recover got %b want 1", ready); end
    tick(); idle(); tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_mul();
    test_contention();
    test_busy_block();
    test_hazard();
    test_guard();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul_div_dispatch.md
# mul_div_dispatch

Issue stage between EX decode and `multiplier_divider_unit`. It accepts MUL/DIV instructions over a valid/ready handshake and buffers them in one holding slot per unit. It launches each instruction as a single-cycle `mul_t` packet only when the target unit is idle, and arbitrates round-robin when both slots are ready in the same cycle. It also produces the RAW/WAW stall for the main pipeline against operations that are held or still in flight.

## Interface
Parameters:
- `REG_ADDR_W`, 5: register address width.
- `XLEN`, 32: operand width.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_flush`  in  1  synchronous pipeline flush. Empties both slots and drops the packet in the current cycle.
- `i_ex_valid`  in  1  an instruction is presented.
- `i_ex_is_mul` / `i_ex_is_div`  in  1 each  target unit; both high is illegal.
- `i_ex_op`  in  2  `mul_op` or `div_op` encoding.
- `i_ex_rs1_data` / `i_ex_rs2_data`  in  XLEN  operand values.
- `i_ex_rd_addr`  in  REG_ADDR_W  destination register.
- `i_ex_wren`  in  1  write enable.
- `o_ex_ready`  out  1  the presented instruction is accepted this cycle.
- `i_chk_valid`  in  1  an EX instruction requests a hazard check.
- `i_chk_rs1_addr` / `i_chk_rs2_addr` / `i_chk_rd_addr`  in  REG_ADDR_W  registers of the checked instruction.
- `o_hazard_stall`  out  1  hold the EX stage.
- `i_mul_fb_dat` / `i_div_fb_dat`  in  `mul_status_t`  busy flag and in-flight rd from each unit.
- `o_abt_mul_dat`  out  `mul_t`  launch packet to `multiplier_divider_unit`.

## Operation
- Each unit has one slot with fields {op, a, b, rd, wren} and a 2-state FSM: EMPTY→FULL on accept, FULL→EMPTY on launch.
- Accept: `o_ex_ready` = `i_ex_valid` & target slot EMPTY & ~`i_flush`.
  - A slot that launches in a cycle does not accept in that same cycle.
  - Accept and launch never overlap on the same slot.
- Eligibility: a slot is eligible when it is FULL & ~unit busy & ~guard.
  - guard: a 1-cycle flag per unit, set in the cycle after that unit launches. It covers the one-cycle latency before the unit's busy flag rises.
- Arbitration: a single launch per cycle.
  - If exactly one slot is eligible, it launches.
  - If both are eligible, the slot the round-robin pointer names launches. The pointer resets to MUL and flips to the other unit after each contended grant.
- Packet contents on launch:
  - `valid`=1 and exactly one of `mul_start`/`div_start`=1.
  - The op is placed in the matching field; the other op field is 0.
  - Operands, rd and wren come from the slot.
  - When no launch occurs, the whole packet is zeros.
- Hazard stall: `o_hazard_stall` = `i_chk_valid` & (any nonzero `i_chk_rs1_addr`/`i_chk_rs2_addr`/`i_chk_rd_addr` equals a pending rd).
  - Pending rd sources:
    - a FULL slot's rd with wren=1;
    - a busy unit's fb rd;
    - a guarded unit's last launched rd.
  - Register x0 never matches.
- Flush: both slots → EMPTY, both guards cleared, pointer kept, packet forced to zero. In-flight unit operations are flushed separately through `i_flush_MUL`/`i_flush_DIV`.
- Illegal input (both `is_mul` and `is_div` high): never accepted; `o_ex_ready`=0.

## Timing
- Reset values:
  - slots EMPTY, guards 0, pointer = MUL;
  - `o_abt_mul_dat` = 0, `o_ex_ready` = 0, `o_hazard_stall` = 0.
- Outputs are combinational from registered state plus current inputs; `o_abt_mul_dat` is driven from the slot registers.
- Minimum latency: accept in cycle N, launch in cycle N+1 when the unit is idle.
- Back-to-back launches to one unit are at least 2 cycles apart because of the guard; after that they are limited by busy.
- A reset asserted mid-operation clears all state immediately, asynchronously. The packet is zero in the same cycle.
- Simultaneous flush and accept: flush wins; nothing is accepted.

## Structure
- `pipeline_pkg` holds:
  - the existing `mul_t` and `mul_status_t`;
  - new `md_slot_t` (slot fields) and the `md_unit_e` {MUL_U, DIV_U} enum, used for the pointer.
- One natural sub-module, `md_issue_slot`, instantiated twice. It holds the slot register, the EMPTY/FULL FSM, the guard flag and the per-slot rd-match logic.
- The top level contains the arbiter, the packet mux and the stall OR.

## Test plan
- **Single MUL:** MUL op=00, a=7, b=6, rd=5 accepted in cycle 0 → cycle 1 packet has `mul_start`=1, `mul_op`=00, a=7, b=6, rd=5. Cycle 2 packet is zero.
- **Contention:** MUL and DIV slots both FULL and both units idle → MUL launches first, DIV launches the next cycle. Repeat → DIV launches first the second time (pointer has flipped).
- **Busy block:** DIV slot FULL while `i_div_fb_dat.busy`=1 for 30 cycles → no DIV launch until the cycle busy falls. A new DIV presented meanwhile sees `o_ex_ready`=0.
- **Hazard:** DIV rd=9 in flight (busy), check with rs2=9 → `o_hazard_stall`=1. Check with rs1=0 while rd=0 is pending → stall=0.
- **Guard:** MUL launched in cycle N with fb busy still 0 in N+1 → no second MUL launch in N+1, and a rd match still stalls.
- **Flush and reset:** `i_flush` with both slots FULL → both EMPTY next cycle and packet zero. Async `i_rst` mid-cycle → all outputs zero immediately.
